// File: rtl/dm_arbiter.sv
// Two-core data-memory arbiter: one single-port RAM shared round-robin between
// cores A and B during a compute run, and owned by the host port otherwise.
module dm_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       ar_a,
  input  logic [15:0]       ar_b,
  input  logic [DATA_W-1:0] wd_a,
  input  logic [DATA_W-1:0] wd_b,
  input  logic              dm_en_a,
  input  logic              dm_en_b,
  input  logic              end_a,
  input  logic              end_b,
  output logic [1:0]        status_a,
  output logic [1:0]        status_b,
  output logic [DATA_W-1:0] dm_out_a,
  output logic [DATA_W-1:0] dm_out_b,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wd,
  output logic [DATA_W-1:0] host_rd,
  output logic              done
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic              grant_b, grant_b_nxt;
  logic              fin_a, fin_a_nxt;
  logic              fin_b, fin_b_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;
  logic              mem_we;
  logic              host_acc;
  logic              core_acc;

  // Upper address bits are dropped so core addresses wrap around the RAM.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{ar_a[15:ADDR_W], ar_b[15:ADDR_W]};

  // Single memory port: host owns it outside RUN, the granted core inside RUN.
  always_comb begin
    host_acc = (state != RUN);
    core_acc = (state == RUN) && !(grant_b ? fin_b : fin_a);
    mem_addr = host_addr;
    mem_wd   = host_wd;
    mem_we   = host_acc && host_we;
    if (state == RUN) begin
      mem_addr = grant_b ? ar_b[ADDR_W-1:0] : ar_a[ADDR_W-1:0];
      mem_wd   = grant_b ? wd_b : wd_a;
      mem_we   = core_acc && (grant_b ? dm_en_b : dm_en_a);
    end
    mem_rd = mem[mem_addr];
  end

  always_comb begin
    state_nxt   = state;
    grant_b_nxt = grant_b;
    fin_a_nxt   = fin_a;
    fin_b_nxt   = fin_b;
    status_a    = 2'b00;
    status_b    = 2'b00;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = RUN;
          grant_b_nxt = 1'b0;
          fin_a_nxt   = 1'b0;
          fin_b_nxt   = 1'b0;
        end
      end
      RUN: begin
        status_a = fin_a ? 2'b10 : (grant_b ? 2'b00 : 2'b01);
        status_b = fin_b ? 2'b10 : (grant_b ? 2'b01 : 2'b00);
        if (fin_a && fin_b) begin
          state_nxt = DONE;
        end else begin
          if (core_acc && !grant_b && end_a) fin_a_nxt = 1'b1;
          if (core_acc && grant_b && end_b)  fin_b_nxt = 1'b1;
          // Alternate while both are active, otherwise park on the survivor.
          case ({fin_a_nxt, fin_b_nxt})
            2'b00:   grant_b_nxt = !grant_b;
            2'b10:   grant_b_nxt = 1'b1;
            2'b01:   grant_b_nxt = 1'b0;
            default: grant_b_nxt = grant_b;
          endcase
        end
      end
      DONE: begin
        status_a = 2'b10;
        status_b = 2'b10;
        done     = 1'b1;
        if (start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      grant_b  <= 1'b0;
      fin_a    <= 1'b0;
      fin_b    <= 1'b0;
      dm_out_a <= '0;
      dm_out_b <= '0;
      host_rd  <= '0;
    end else begin
      state   <= state_nxt;
      grant_b <= grant_b_nxt;
      fin_a   <= fin_a_nxt;
      fin_b   <= fin_b_nxt;
      if (host_acc)             host_rd  <= mem_rd;
      if (core_acc && !grant_b) dm_out_a <= mem_rd;
      if (core_acc && grant_b)  dm_out_b <= mem_rd;
    end
  end

  // Read-first RAM: reads above see the old word; reset blocks the write.
  always_ff @(posedge clock) begin
    if (!reset && mem_we) mem[mem_addr] <= mem_wd;
  end

endmodule
